// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - I/D-cache to L2 arbiter bus bundle
// Groups the I-cache, D-cache and L2 controller handshake signals.
//   slave  : arbiter view (requests in, L2 strobes and responses out)
//   master : environment view (caches and L2 controller)
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
        output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - arbitrates I-cache and D-cache line requests onto one L2 port
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cache_arbiter_if.slave (I/D request/response, L2 request/response)
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN
//   defined   -> conflicts resolved round-robin, I preferred after reset
//   undefined -> fixed priority, D-cache wins conflicts
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;

    logic req_i;
    logic req_d;
    logic pick_d;

    assign req_i = bus.i_read;
    assign req_d = bus.d_read | bus.d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic prefer_i_q, prefer_i_d;
    // D wins when it is the only requester, or on a conflict when I was granted last.
    assign pick_d = req_d & (~req_i | ~prefer_i_q);
`else
    assign pick_d = req_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        prefer_i_d = prefer_i_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = GRANT_D;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    // read+write together is a write-back
                    wr_d    = bus.d_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    prefer_i_d = 1'b1;
`endif
                end else if (req_i) begin
                    state_d = GRANT_I;
                    addr_d  = bus.i_addr;
                    wdata_d = '0;
                    wr_d    = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    prefer_i_d = 1'b0;
`endif
                end
            end
            // Requester level is ignored here; only L2 completion ends the grant,
            // and returning to IDLE gives the mandatory bubble cycle.
            GRANT_I, GRANT_D: begin
                if (bus.l2_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            prefer_i_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            prefer_i_q <= prefer_i_d;
`endif
        end
    end

    // Strobes decode from registered state only, so reset clears them immediately.
    assign bus.l2_read  = (state_q != IDLE) & ~wr_q;
    assign bus.l2_write = (state_q != IDLE) &  wr_q;
    assign bus.l2_addr  = addr_q;
    assign bus.l2_wdata = wdata_q;

    assign bus.i_resp   = (state_q == GRANT_I) & bus.l2_resp;
    assign bus.d_resp   = (state_q == GRANT_D) & bus.l2_resp;
    assign bus.i_rdata  = bus.l2_rdata;
    assign bus.d_rdata  = bus.l2_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed vector bench for cache_arbiter
module tb_cache_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam logic [ADDR_W-1:0] I_ADDR = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] D_ADDR = 32'h0000_2040;
    localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_5A = {32{8'h5A}};

    // strobe encoding {l2_read, l2_write, i_resp, d_resp}
    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_RD   = 4'b1000;
    localparam logic [3:0] S_WR   = 4'b0100;
    localparam logic [3:0] S_RD_I = 4'b1010;
    localparam logic [3:0] S_RD_D = 4'b1001;
    localparam logic [3:0] S_WR_D = 4'b0101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp};
    endfunction

    typedef struct {
        logic       ir;
        logic       dr;
        logic       dw;
        logic       rsp;
        logic [3:0] exp;
        int         sel;   // 0: no address check, 1: I address, 2: D address
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ir, input logic dr, input logic dw, input logic rsp,
                       input logic [3:0] exp, input int sel);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.rsp = rsp; v.exp = exp; v.sel = sel;
        vecs.push_back(v);
    endtask

    int order[5];

    initial begin
        // single I read, L2 answers three cycles into the grant
        add(1, 0, 0, 0, S_NONE, 0);
        add(1, 0, 0, 0, S_RD,   1);
        add(1, 0, 0, 0, S_RD,   1);
        add(1, 0, 0, 0, S_RD,   1);
        add(1, 0, 0, 1, S_RD_I, 1);
        add(0, 0, 0, 0, S_NONE, 0);
        // D write-back
        add(0, 0, 1, 0, S_NONE, 0);
        add(0, 0, 1, 0, S_WR,   2);
        add(0, 0, 1, 1, S_WR_D, 2);
        add(0, 0, 0, 0, S_NONE, 0);
        // stray l2_resp in IDLE
        add(0, 0, 0, 1, S_NONE, 0);
        add(0, 0, 0, 0, S_NONE, 0);
        // d_read and d_write together is a write
        add(0, 1, 1, 0, S_NONE, 0);
        add(0, 1, 1, 0, S_WR,   2);
        add(0, 1, 1, 1, S_WR_D, 2);
        add(0, 0, 0, 0, S_NONE, 0);
        // D requester drops after grant
        add(0, 1, 0, 0, S_NONE, 0);
        add(0, 1, 0, 0, S_RD,   2);
        add(0, 0, 0, 0, S_RD,   2);
        add(0, 0, 0, 0, S_RD,   2);
        add(0, 0, 0, 1, S_RD_D, 2);
        add(0, 0, 0, 0, S_NONE, 0);
        add(0, 0, 0, 0, S_NONE, 0);
        // I held past completion: bubble cycle, then re-grant
        add(1, 0, 0, 0, S_NONE, 0);
        add(1, 0, 0, 0, S_RD,   1);
        add(1, 0, 0, 1, S_RD_I, 1);
        add(1, 0, 0, 0, S_NONE, 0);
        add(0, 0, 0, 0, S_RD,   1);
        add(0, 0, 0, 1, S_RD_I, 1);
        add(0, 0, 0, 0, S_NONE, 0);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
        order = '{1, 2, 1, 2, 1};
`else
        order = '{2, 2, 2, 2, 1};
`endif

        bus.i_read   = 1'b1;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        bus.i_addr   = I_ADDR;
        bus.d_addr   = D_ADDR;
        bus.d_wdata  = PAT_5A;
        bus.l2_rdata = PAT_A5;
        bus.l2_resp  = 1'b1;

        // reset state, with a request and stray l2_resp present
        @(negedge clk);
        #1;
        check("reset_strobes", strobes(), S_NONE);
        check("reset_l2_addr", bus.l2_addr, '0);
        check("reset_l2_wdata", bus.l2_wdata, '0);
        bus.i_read  = 1'b0;
        bus.l2_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            bus.i_read  = vecs[k].ir;
            bus.d_read  = vecs[k].dr;
            bus.d_write = vecs[k].dw;
            bus.l2_resp = vecs[k].rsp;
            #1;
            check($sformatf("vec%0d_strobes", k), strobes(), vecs[k].exp);
            if (vecs[k].sel == 1) check($sformatf("vec%0d_addr", k), bus.l2_addr, I_ADDR);
            if (vecs[k].sel == 2) check($sformatf("vec%0d_addr", k), bus.l2_addr, D_ADDR);
            if (vecs[k].exp[2]) check($sformatf("vec%0d_wdata", k), bus.l2_wdata, PAT_5A);
            if (vecs[k].exp[1]) check($sformatf("vec%0d_i_rdata", k), bus.i_rdata, PAT_A5);
            if (vecs[k].exp[0]) check($sformatf("vec%0d_d_rdata", k), bus.d_rdata, PAT_A5);
        end

        // conflict: both requesters held from reset
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_read  = 1'b1;
        bus.d_read  = 1'b1;
        bus.d_write = 1'b0;
        bus.l2_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("conf%0d_strobes", g), strobes(), S_RD);
            check($sformatf("conf%0d_addr", g), bus.l2_addr, (order[g] == 1) ? I_ADDR : D_ADDR);
            bus.l2_resp = 1'b1;
            #1;
            check($sformatf("conf%0d_resp", g), strobes(), (order[g] == 1) ? S_RD_I : S_RD_D);
            @(posedge clk);
            @(negedge clk);
            bus.l2_resp = 1'b0;
            if (g == 3) bus.d_read = 1'b0;
            if (g == 4) bus.i_read = 1'b0;
            #1;
            check($sformatf("conf%0d_bubble", g), strobes(), S_NONE);
        end

        // reset in the middle of an I grant
        @(negedge clk);
        bus.i_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstmid_grant", strobes(), S_RD);
        rst_n = 1'b0;
        #1;
        check("rstmid_strobes_low", strobes(), S_NONE);
        bus.i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.l2_resp = 1'b1;
        #1;
        check("rstmid_late_resp", strobes(), S_NONE);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstmid_idle", strobes(), S_NONE);
        bus.l2_resp = 1'b0;
        bus.d_read  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstmid_regrant", strobes(), S_RD);
        check("rstmid_regrant_addr", bus.l2_addr, D_ADDR);
        bus.l2_resp = 1'b1;
        #1;
        check("rstmid_regrant_resp", strobes(), S_RD_D);
        @(posedge clk);
        @(negedge clk);
        bus.l2_resp = 1'b0;
        bus.d_read  = 1'b0;
        #1;
        check("rstmid_final_idle", strobes(), S_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
